// File: rtl/min_max_pkg.sv
// Shared types and saturating/clamping helpers for the min/max LED bar family.
// Helpers work on a wide carrier type; callers narrow the result to their own width.
package min_max_pkg;

    localparam int VAL_W_MAX = 16;

    typedef logic [VAL_W_MAX-1:0] val_wide_t;

    typedef enum logic [1:0] {
        COM_NORMAL  = 2'b00,
        COM_LINEAR  = 2'b01,
        COM_ALL_OFF = 2'b10,
        COM_ALL_ON  = 2'b11
    } com_t;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    function automatic val_wide_t clamp(input val_wide_t v, input val_wide_t lo, input val_wide_t hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    // Step up by one unless already at (or above) the ceiling.
    function automatic val_wide_t sat_inc(input val_wide_t v, input val_wide_t top);
        if (v < top) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic val_wide_t sat_dec(input val_wide_t v, input val_wide_t bottom);
        if (v > bottom) begin
            return v - 16'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/min_max_stim_ctrl_osc_gen.sv
// Free-running prescaler producing the blink square wave and a once-per-period tick.
module osc_gen #(
    parameter int OSC_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic osc_o,
    output logic tick_o
);

    localparam int CNT_W = $clog2(OSC_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSC_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == CNT_LAST);
    // Tick only on the wrap that ends the high half, so one pulse per full period.
    assign tick_o = wrap_s & osc_o;

    // Prescaler count and square-wave toggle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
            osc_o <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= {CNT_W{1'b0}};
            osc_o <= ~osc_o;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            osc_o <= osc_o;
        end
    end

endmodule

// File: rtl/min_max_stim_ctrl.sv
// Switch/button conditioner for min_max_top: registered com/min/max/value bus,
// manual inc/dec editing and an automatic bounce sweep paced by the blink period.
module min_max_stim_ctrl
    import min_max_pkg::*;
#(
    parameter int VALSIZE = 4,
    parameter int OSC_DIV = 1000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         com_sw_i,
    input  logic [VALSIZE-1:0] min_sw_i,
    input  logic [VALSIZE-1:0] max_sw_i,
    input  logic [VALSIZE-1:0] val_sw_i,
    input  logic               load_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               auto_i,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o,
    output logic               sweep_o
);

    typedef logic [VALSIZE-1:0] val_t;

    localparam val_t VAL_TOP  = {VALSIZE{1'b1}};
    localparam val_t VAL_ZERO = {VALSIZE{1'b0}};

    function automatic val_t clamp_v(input val_t v, input val_t lo, input val_t hi);
        return val_t'(clamp(val_wide_t'(v), val_wide_t'(lo), val_wide_t'(hi)));
    endfunction

    function automatic val_t inc_v(input val_t v, input val_t top);
        return val_t'(sat_inc(val_wide_t'(v), val_wide_t'(top)));
    endfunction

    function automatic val_t dec_v(input val_t v, input val_t bottom);
        return val_t'(sat_dec(val_wide_t'(v), val_wide_t'(bottom)));
    endfunction

    logic   tick_s;
    logic   load_q_r, inc_q_r, dec_q_r;
    logic   load_e_s, inc_e_s, dec_e_s;
    state_t state_r, state_s;
    logic [1:0] com_s;
    val_t   min_s, max_s, val_s;

    osc_gen #(.OSC_DIV(OSC_DIV)) u_osc_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .osc_o  (osc_o),
        .tick_o (tick_s)
    );

    assign load_e_s = load_i & ~load_q_r;
    assign inc_e_s  = inc_i & ~inc_q_r;
    assign dec_e_s  = dec_i & ~dec_q_r;

    // Next-state: load first, then the mode-specific update applied on top of it.
    always_comb begin
        state_s = state_r;
        com_s   = com_o;
        min_s   = min_o;
        max_s   = max_o;
        val_s   = val_o;
        if (load_e_s) begin
            com_s = com_sw_i;
            val_s = val_sw_i;
            if (min_sw_i <= max_sw_i) begin
                min_s = min_sw_i;
                max_s = max_sw_i;
            end else begin
                min_s = max_sw_i;
                max_s = min_sw_i;
            end
        end else begin
            com_s = com_o;
        end
        case (state_r)
            MANUAL: begin
                if (auto_i) begin
                    state_s = SWEEP_UP;
                    val_s   = clamp_v(val_s, min_s, max_s);
                end else if (load_e_s) begin
                    state_s = MANUAL;
                end else if (inc_e_s && !dec_e_s) begin
                    val_s = inc_v(val_o, VAL_TOP);
                end else if (dec_e_s && !inc_e_s) begin
                    val_s = dec_v(val_o, VAL_ZERO);
                end else begin
                    val_s = val_o;
                end
            end
            SWEEP_UP, SWEEP_DOWN: begin
                if (load_e_s) begin
                    val_s = clamp_v(val_s, min_s, max_s);
                end else begin
                    val_s = val_o;
                end
                // A load in the same cycle swallows the tick.
                if (!auto_i) begin
                    state_s = MANUAL;
                end else if (tick_s && !load_e_s) begin
                    if (state_r == SWEEP_UP) begin
                        if (val_o < max_o) begin
                            val_s = inc_v(val_o, max_o);
                        end else begin
                            state_s = SWEEP_DOWN;
                            val_s   = dec_v(val_o, min_o);
                        end
                    end else begin
                        if (val_o > min_o) begin
                            val_s = dec_v(val_o, min_o);
                        end else begin
                            state_s = SWEEP_UP;
                            val_s   = inc_v(val_o, max_o);
                        end
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = MANUAL;
            end
        endcase
    end

    // State, edge-detect history and the registered output bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= MANUAL;
            load_q_r <= 1'b0;
            inc_q_r  <= 1'b0;
            dec_q_r  <= 1'b0;
            com_o    <= COM_NORMAL;
            min_o    <= VAL_ZERO;
            max_o    <= VAL_TOP;
            val_o    <= VAL_ZERO;
            sweep_o  <= 1'b0;
        end else begin
            state_r  <= state_s;
            load_q_r <= load_i;
            inc_q_r  <= inc_i;
            dec_q_r  <= dec_i;
            com_o    <= com_s;
            min_o    <= min_s;
            max_o    <= max_s;
            val_o    <= val_s;
            sweep_o  <= (state_s != MANUAL);
        end
    end

endmodule

// File: tb/tb_min_max_stim_ctrl.sv
// Bench for min_max_stim_ctrl: directed table, hand-written sweep/reset sequences
// and random stimulus, all compared against an arithmetic reference model.
module tb_min_max_stim_ctrl;

    localparam int VS   = 4;
    localparam int OD   = 4;
    localparam int TOPV = (1 << VS) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]    com_sw = 2'd0;
    logic [VS-1:0] min_sw = 4'd0, max_sw = 4'd0, val_sw = 4'd0;
    logic load = 1'b0, inc = 1'b0, dec = 1'b0, auto_en = 1'b0;
    logic [1:0]    com_o;
    logic [VS-1:0] min_o, max_o, val_o;
    logic osc_o, sweep_o;

    int n_vec = 0;
    int n_err = 0;

    int m_com, m_min, m_max, m_val, m_edges, m_dir;
    bit m_sweep, m_lq, m_iq, m_dq;

    typedef struct {
        logic ld, in, dn;
        logic [1:0] com;
        logic [VS-1:0] mn, mx, vl;
        int reps;
        int e_com, e_min, e_max, e_val;
    } vec_t;
    vec_t tbl[$];

    min_max_stim_ctrl #(.VALSIZE(VS), .OSC_DIV(OD)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .com_sw_i(com_sw),
        .min_sw_i(min_sw),
        .max_sw_i(max_sw),
        .val_sw_i(val_sw),
        .load_i  (load),
        .inc_i   (inc),
        .dec_i   (dec),
        .auto_i  (auto_en),
        .com_o   (com_o),
        .min_o   (min_o),
        .max_o   (max_o),
        .val_o   (val_o),
        .osc_o   (osc_o),
        .sweep_o (sweep_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_com = 0; m_min = 0; m_max = TOPV; m_val = 0;
        m_edges = 0; m_dir = 1; m_sweep = 0;
        m_lq = 0; m_iq = 0; m_dq = 0;
    endtask

    // One clock edge of the behaviour, from the rules in plain arithmetic.
    task automatic model_step();
        bit ld, ie, de, tick;
        m_edges++;
        tick = (m_edges % (2 * OD)) == 0;
        ld = load && !m_lq;
        ie = inc && !m_iq;
        de = dec && !m_dq;
        if (ld) begin
            m_com = int'(com_sw);
            m_min = (min_sw < max_sw) ? int'(min_sw) : int'(max_sw);
            m_max = (min_sw < max_sw) ? int'(max_sw) : int'(min_sw);
            m_val = int'(val_sw);
        end
        if (!m_sweep) begin
            if (auto_en) begin
                m_sweep = 1; m_dir = 1;
                m_val = clampi(m_val, m_min, m_max);
            end else if (!ld) begin
                if (ie && !de && m_val < TOPV) m_val++;
                else if (de && !ie && m_val > 0) m_val--;
            end
        end else begin
            if (ld) m_val = clampi(m_val, m_min, m_max);
            if (!auto_en) m_sweep = 0;
            else if (tick && !ld) begin
                if (m_dir > 0) begin
                    if (m_val < m_max) m_val++;
                    else begin m_dir = -1; if (m_val > m_min) m_val--; end
                end else begin
                    if (m_val > m_min) m_val--;
                    else begin m_dir = 1; if (m_val < m_max) m_val++; end
                end
            end
        end
        m_lq = load; m_iq = inc; m_dq = dec;
    endtask

    task automatic check_model();
        chk("model_com",   32'(com_o),   m_com);
        chk("model_min",   32'(min_o),   m_min);
        chk("model_max",   32'(max_o),   m_max);
        chk("model_val",   32'(val_o),   m_val);
        chk("model_osc",   32'(osc_o),   (m_edges / OD) % 2);
        chk("model_sweep", 32'(sweep_o), 32'(m_sweep));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values();
        chk("rst_com", 32'(com_o), 0);
        chk("rst_min", 32'(min_o), 0);
        chk("rst_max", 32'(max_o), TOPV);
        chk("rst_val", 32'(val_o), 0);
        chk("rst_osc", 32'(osc_o), 0);
        chk("rst_sweep", 32'(sweep_o), 0);
    endtask

    // Assert reset between edges, check it acts at once, release on a falling edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_values();
        load = 0; inc = 0; dec = 0; auto_en = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_osc_start();
        for (int e = 1; e <= 8; e++) begin
            cycle();
            if (e == 3) chk("osc_edge3", 32'(osc_o), 0);
            if (e == 4) chk("osc_edge4", 32'(osc_o), 1);
            if (e == 7) chk("osc_edge7", 32'(osc_o), 1);
            if (e == 8) chk("osc_edge8", 32'(osc_o), 0);
        end
    endtask

    task automatic add(input logic ld, input logic in, input logic dn, input logic [1:0] com,
                       input logic [VS-1:0] mn, input logic [VS-1:0] mx, input logic [VS-1:0] vl,
                       input int reps, input int ec, input int emn, input int emx, input int ev);
        vec_t v;
        v.ld = ld; v.in = in; v.dn = dn; v.com = com;
        v.mn = mn; v.mx = mx; v.vl = vl; v.reps = reps;
        v.e_com = ec; v.e_min = emn; v.e_max = emx; v.e_val = ev;
        tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int exp_seq[5];
        int w;
        exp_seq = '{4, 3, 4, 5, 4};

        // Power-on reset, then disturb the outputs and pulse reset asynchronously.
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        load = 1; com_sw = 2'd3; min_sw = 4'd1; max_sw = 4'd2; val_sw = 4'd2;
        repeat (5) cycle();
        pulse_reset();
        check_osc_start();

        add(1,0,0, 2'd1, 4'd12, 4'd3,  4'd8,  1, 1, 3, 12, 8);
        add(1,0,0, 2'd0, 4'd0,  4'd0,  4'd0,  4, 1, 3, 12, 8);
        add(0,0,0, 2'd0, 4'd0,  4'd0,  4'd0,  1, 1, 3, 12, 8);
        add(1,0,0, 2'd0, 4'd0,  4'd15, 4'd15, 1, 0, 0, 15, 15);
        add(0,1,0, 2'd0, 4'd0,  4'd15, 4'd15, 2, 0, 0, 15, 15);
        add(0,0,0, 2'd0, 4'd0,  4'd15, 4'd15, 1, 0, 0, 15, 15);
        add(1,0,0, 2'd0, 4'd0,  4'd15, 4'd0,  1, 0, 0, 15, 0);
        add(0,0,1, 2'd0, 4'd0,  4'd15, 4'd0,  2, 0, 0, 15, 0);
        add(0,0,0, 2'd0, 4'd0,  4'd15, 4'd0,  1, 0, 0, 15, 0);
        add(1,0,0, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 7);
        add(0,1,1, 2'd0, 4'd0,  4'd15, 4'd7,  2, 0, 0, 15, 7);
        add(0,0,0, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 7);
        add(0,1,0, 2'd0, 4'd0,  4'd15, 4'd7, 10, 0, 0, 15, 8);
        add(0,0,0, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 8);
        add(0,0,1, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 7);
        add(0,1,0, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 8);
        add(0,0,0, 2'd0, 4'd0,  4'd15, 4'd7,  1, 0, 0, 15, 8);
        add(1,0,0, 2'd2, 4'd3,  4'd5,  4'd9,  1, 2, 3, 5, 9);
        add(0,0,0, 2'd2, 4'd3,  4'd5,  4'd9,  1, 2, 3, 5, 9);

        for (int i = 0; i < tbl.size(); i++) begin
            load = tbl[i].ld; inc = tbl[i].in; dec = tbl[i].dn;
            com_sw = tbl[i].com; min_sw = tbl[i].mn; max_sw = tbl[i].mx; val_sw = tbl[i].vl;
            for (int r = 0; r < tbl[i].reps; r++) begin
                cycle();
                chk("tbl_com", 32'(com_o), tbl[i].e_com);
                chk("tbl_min", 32'(min_o), tbl[i].e_min);
                chk("tbl_max", 32'(max_o), tbl[i].e_max);
                chk("tbl_val", 32'(val_o), tbl[i].e_val);
            end
        end

        // Sweep entry clamps 9 into [3,5], then bounces on each tick.
        auto_en = 1;
        cycle();
        chk("sweep_entry_val", 32'(val_o), 5);
        chk("sweep_entry_flag", 32'(sweep_o), 1);
        prev = 5;
        for (int j = 0; j < 5; j++) begin
            w = 0;
            while (val_o == prev[VS-1:0] && w < 20) begin
                cycle();
                w++;
            end
            if (w >= 20) begin
                n_vec++; n_err++;
                $display("FAIL bounce_timeout: val stuck at %0d, expected %0d", val_o, exp_seq[j]);
            end else begin
                chk("bounce_val", 32'(val_o), exp_seq[j]);
            end
            prev = exp_seq[j];
        end
        auto_en = 0;
        cycle();
        chk("sweep_exit_val", 32'(val_o), 4);
        chk("sweep_exit_flag", 32'(sweep_o), 0);

        // Degenerate range: value pinned while the direction keeps flipping.
        load = 1; min_sw = 4'd7; max_sw = 4'd7; val_sw = 4'd2;
        cycle();
        chk("degen_load_val", 32'(val_o), 2);
        load = 0; auto_en = 1;
        cycle();
        chk("degen_entry_val", 32'(val_o), 7);
        for (int k = 0; k < 32; k++) begin
            cycle();
            chk("degen_val", 32'(val_o), 7);
        end

        // Load during a sweep clamps the new value and the sweep carries on.
        load = 1; min_sw = 4'd4; max_sw = 4'd2; val_sw = 4'd14;
        cycle();
        chk("sweep_load_val", 32'(val_o), 4);
        chk("sweep_load_min", 32'(min_o), 2);
        chk("sweep_load_max", 32'(max_o), 4);
        chk("sweep_load_flag", 32'(sweep_o), 1);
        load = 0;
        repeat (24) cycle();

        pulse_reset();
        check_osc_start();
        chk("post_rst_sweep", 32'(sweep_o), 0);

        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) inc = ~inc;
            if ($urandom_range(0, 3) == 0) dec = ~dec;
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            com_sw = 2'($urandom);
            min_sw = 4'($urandom);
            max_sw = 4'($urandom);
            val_sw = 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
